match_judge: RTL and testbench

MATCH_JUDGE -- requirements
Module: match_judge

---
 rtl/match_pkg.sv | 51 +++++
 rtl/match_judge_rps_compare.sv | 39 +++
 rtl/match_judge.sv | 195 +++++++++++++++++++
 tb/tb_match_judge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// ---------------------------------------------------------------------------
// match_pkg
// Shared definitions for the rock/paper/scissors match judge:
//   - move encodings (2 bits, 00 is an illegal / empty move)
//   - match result encodings driven on match_judge.matchresult
//   - FSM state type of the judge
//   - small helpers used by the decision logic and the acceptance logic
// ---------------------------------------------------------------------------
package match_pkg;

    typedef enum logic [1:0] {
        MOVE_ILLEGAL  = 2'b00,
        MOVE_ROCK     = 2'b01,
        MOVE_PAPER    = 2'b10,
        MOVE_SCISSORS = 2'b11
    } move_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_DRAW   = 2'b01,
        RES_P1_WIN = 2'b10,
        RES_P2_WIN = 2'b11
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HAVE_P1 = 3'd1,
        ST_HAVE_P2 = 3'd2,
        ST_JUDGE   = 3'd3,
        ST_REPORT  = 3'd4
    } state_e;

    // A move is usable only when it carries one of the three real shapes.
    function automatic logic move_is_legal(input logic [1:0] mv);
        return (mv != MOVE_ILLEGAL);
    endfunction

    // True when shape a defeats shape b (rock>scissors, scissors>paper, paper>rock).
    function automatic logic move_beats(input logic [1:0] a, input logic [1:0] b);
        logic win;
        win = 1'b0;
        case ({a, b})
            {MOVE_ROCK,     MOVE_SCISSORS}: win = 1'b1;
            {MOVE_SCISSORS, MOVE_PAPER}:    win = 1'b1;
            {MOVE_PAPER,    MOVE_ROCK}:     win = 1'b1;
            default:                        win = 1'b0;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/match_judge_rps_compare.sv
// ---------------------------------------------------------------------------
// rps_compare
// Purely combinational decision logic for one match.
// Ports:
//   p1_move, p2_move   in  2  captured moves (match_pkg move encoding)
//   p1_forfeit         in  1  player 1 ran out of time (player 2 wins)
//   p2_forfeit         in  1  player 2 ran out of time (player 1 wins)
//   result             out 2  match_pkg result encoding
// A forfeit overrides the shapes, since the forfeiting player never moved.
// ---------------------------------------------------------------------------
module rps_compare
    import match_pkg::*;
(
    input  logic [1:0] p1_move,
    input  logic [1:0] p2_move,
    input  logic       p1_forfeit,
    input  logic       p2_forfeit,
    output logic [1:0] result
);

    // Decide winner from forfeit flags first, then from the two shapes.
    always_comb begin
        result = RES_NONE;
        if (p2_forfeit) begin
            result = RES_P1_WIN;
        end else if (p1_forfeit) begin
            result = RES_P2_WIN;
        end else if (!move_is_legal(p1_move) || !move_is_legal(p2_move)) begin
            result = RES_NONE;
        end else if (p1_move == p2_move) begin
            result = RES_DRAW;
        end else if (move_beats(p1_move, p2_move)) begin
            result = RES_P1_WIN;
        end else begin
            result = RES_P2_WIN;
        end
    end

endmodule

// File: rtl/match_judge.sv
// ---------------------------------------------------------------------------
// match_judge
// Collects one move from each player, judges the pair and emits a one-cycle
// result pulse for the score-update stage.
// Parameters:
//   TIMEOUT_CYCLES  1..255, cycles a lone move waits before the opponent
//                   forfeits (only with MATCH_JUDGE_TIMEOUT_EN defined)
// Optional feature macro: MATCH_JUDGE_TIMEOUT_EN (forfeit timeout).
// Ports:
//   clk          in   1  clock, rising edge
//   resetn       in   1  asynchronous reset, active HIGH despite the name
//   p1_valid     in   1  player-1 move offered
//   p1_move      in   2  player-1 move (01 rock, 10 paper, 11 scissors)
//   p2_valid     in   1  player-2 move offered
//   p2_move      in   2  player-2 move
//   p1_ready     out  1  player-1 move can be accepted this cycle
//   p2_ready     out  1  player-2 move can be accepted this cycle
//   matchresult  out  2  00 none, 01 draw, 10 p1 wins, 11 p2 wins
//   busy         out  1  high whenever the FSM is not IDLE
// All outputs come straight from flops; ready/busy are loaded from the
// next-state decode so they always describe the current state.
// ---------------------------------------------------------------------------
module match_judge
    import match_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p1_ready,
    output logic       p2_ready,
    output logic [1:0] matchresult,
    output logic       busy
);

    state_e     state_r;
    state_e     next_state_s;
    logic [1:0] p1_move_r;
    logic [1:0] p2_move_r;
    logic       p1_forfeit_r;
    logic       p2_forfeit_r;
    logic       p1_ok_s;
    logic       p2_ok_s;
    logic       p1_load_s;
    logic       p2_load_s;
    logic       p1_forfeit_set_s;
    logic       p2_forfeit_set_s;
    logic       timeout_s;
    logic [1:0] decision_s;
    logic [1:0] match_result_r;
    logic       p1_ready_r;
    logic       p2_ready_r;
    logic       busy_r;

    assign p1_ok_s = p1_valid && move_is_legal(p1_move);
    assign p2_ok_s = p2_valid && move_is_legal(p2_move);

`ifdef MATCH_JUDGE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_r;

    // Wait counter: zero outside the HAVE states, so it starts at 0 on entry.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == ST_HAVE_P1) || (state_r == ST_HAVE_P2)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    // The edge on which the counter would reach TIMEOUT_CYCLES.
    assign timeout_s = ((state_r == ST_HAVE_P1) || (state_r == ST_HAVE_P2)) &&
                       (wait_cnt_r == TMO_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, move capture and forfeit decisions.
    always_comb begin
        next_state_s     = state_r;
        p1_load_s        = 1'b0;
        p2_load_s        = 1'b0;
        p1_forfeit_set_s = 1'b0;
        p2_forfeit_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                p1_load_s = p1_ok_s;
                p2_load_s = p2_ok_s;
                if (p1_ok_s && p2_ok_s) begin
                    next_state_s = ST_JUDGE;
                end else if (p1_ok_s) begin
                    next_state_s = ST_HAVE_P1;
                end else if (p2_ok_s) begin
                    next_state_s = ST_HAVE_P2;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HAVE_P1: begin
                p2_load_s = p2_ok_s;
                // A real opponent move beats a simultaneous timeout.
                if (p2_ok_s) begin
                    next_state_s = ST_JUDGE;
                end else if (timeout_s) begin
                    next_state_s     = ST_JUDGE;
                    p2_forfeit_set_s = 1'b1;
                end else begin
                    next_state_s = ST_HAVE_P1;
                end
            end
            ST_HAVE_P2: begin
                p1_load_s = p1_ok_s;
                if (p1_ok_s) begin
                    next_state_s = ST_JUDGE;
                end else if (timeout_s) begin
                    next_state_s     = ST_JUDGE;
                    p1_forfeit_set_s = 1'b1;
                end else begin
                    next_state_s = ST_HAVE_P2;
                end
            end
            ST_JUDGE:  next_state_s = ST_REPORT;
            ST_REPORT: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    rps_compare u_rps_compare (
        .p1_move    (p1_move_r),
        .p2_move    (p2_move_r),
        .p1_forfeit (p1_forfeit_r),
        .p2_forfeit (p2_forfeit_r),
        .result     (decision_s)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r        <= ST_IDLE;
            match_result_r <= RES_NONE;
            p1_ready_r     <= 1'b1;
            p2_ready_r     <= 1'b1;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            // Result is non-zero only during REPORT, i.e. after the JUDGE edge.
            match_result_r <= (state_r == ST_JUDGE) ? decision_s : RES_NONE;
            p1_ready_r     <= (next_state_s == ST_IDLE) || (next_state_s == ST_HAVE_P2);
            p2_ready_r     <= (next_state_s == ST_IDLE) || (next_state_s == ST_HAVE_P1);
            busy_r         <= (next_state_s != ST_IDLE);
        end
    end

    // Captured moves and forfeit flags; wiped when REPORT hands back to IDLE.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            p1_move_r    <= MOVE_ILLEGAL;
            p2_move_r    <= MOVE_ILLEGAL;
            p1_forfeit_r <= 1'b0;
            p2_forfeit_r <= 1'b0;
        end else if (state_r == ST_REPORT) begin
            p1_move_r    <= MOVE_ILLEGAL;
            p2_move_r    <= MOVE_ILLEGAL;
            p1_forfeit_r <= 1'b0;
            p2_forfeit_r <= 1'b0;
        end else begin
            if (p1_load_s) begin
                p1_move_r <= p1_move;
            end
            if (p2_load_s) begin
                p2_move_r <= p2_move;
            end
            if (p1_forfeit_set_s) begin
                p1_forfeit_r <= 1'b1;
            end
            if (p2_forfeit_set_s) begin
                p2_forfeit_r <= 1'b1;
            end
        end
    end

    assign p1_ready    = p1_ready_r;
    assign p2_ready    = p2_ready_r;
    assign matchresult = match_result_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_match_judge.sv
// ---------------------------------------------------------------------------
// tb_match_judge
// Directed self-checking bench for match_judge. Inputs change 1 time unit
// after a rising edge and outputs are checked at that same point, away from
// the active edge. Expected values are written out by hand per step.
// With MATCH_JUDGE_TIMEOUT_EN defined the forfeit paths are exercised with
// TIMEOUT_CYCLES = 4; otherwise an indefinite wait is checked instead.
// ---------------------------------------------------------------------------
module tb_match_judge;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       p1_valid = 1'b0;
    logic [1:0] p1_move = 2'b00;
    logic       p2_valid = 1'b0;
    logic [1:0] p2_move = 2'b00;
    logic       p1_ready;
    logic       p2_ready;
    logic [1:0] matchresult;
    logic       busy;

    int errors = 0;
    int checks = 0;

`ifdef MATCH_JUDGE_TIMEOUT_EN
    localparam int B_WAIT = 4;   // p2 arrives on the timeout edge itself
`else
    localparam int B_WAIT = 5;
`endif

    match_judge #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .p1_valid    (p1_valid),
        .p1_move     (p1_move),
        .p2_valid    (p2_valid),
        .p2_move     (p2_move),
        .p1_ready    (p1_ready),
        .p2_ready    (p2_ready),
        .matchresult (matchresult),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_p1_ready"}, {1'b0, p1_ready}, 2'b01);
        chk({tag, "_p2_ready"}, {1'b0, p2_ready}, 2'b01);
        chk({tag, "_busy"}, {1'b0, busy}, 2'b00);
        chk({tag, "_result"}, matchresult, 2'b00);
    endtask

    // Offer one move per player on the same edge, then follow the pulse.
    task automatic both_same_edge(input string tag, input logic [1:0] m1,
                                  input logic [1:0] m2, input logic [1:0] res);
        p1_valid = 1'b1; p1_move = m1;
        p2_valid = 1'b1; p2_move = m2;
        tick();                                     // accepted -> JUDGE
        p1_valid = 1'b0; p2_valid = 1'b0;
        chk({tag, "_judge_result"}, matchresult, 2'b00);
        chk({tag, "_judge_p1_ready"}, {1'b0, p1_ready}, 2'b00);
        chk({tag, "_judge_busy"}, {1'b0, busy}, 2'b01);
        tick();                                     // -> REPORT
        chk({tag, "_report_result"}, matchresult, res);
        chk({tag, "_report_p2_ready"}, {1'b0, p2_ready}, 2'b00);
        tick();                                     // -> IDLE
        idle_outputs({tag, "_after"});
    endtask

    initial begin
        // Reset asserted from time zero
        #12;
        idle_outputs("reset");
        tick();
        resetn = 1'b0;

        // Rock vs scissors on one edge: p1 wins, one-cycle pulse
        both_same_edge("rock_scis", 2'b01, 2'b11, 2'b10);
        // Draw
        both_same_edge("draw", 2'b01, 2'b01, 2'b01);
        // Paper vs rock: p1 wins
        both_same_edge("paper_rock", 2'b10, 2'b01, 2'b10);
        // Scissors vs paper: p1 wins
        both_same_edge("scis_paper", 2'b11, 2'b10, 2'b10);
        // Rock vs paper: p2 wins
        both_same_edge("rock_paper", 2'b01, 2'b10, 2'b11);

        // Illegal 00 move in IDLE is ignored
        p1_valid = 1'b1; p1_move = 2'b00;
        tick();
        idle_outputs("illegal_idle1");
        tick();
        idle_outputs("illegal_idle2");

        // p1 illegal with p2 paper -> HAVE_P2 only
        p2_valid = 1'b1; p2_move = 2'b10;
        tick();
        chk("hp2_p2_ready", {1'b0, p2_ready}, 2'b00);
        chk("hp2_p1_ready", {1'b0, p1_ready}, 2'b01);
        chk("hp2_busy", {1'b0, busy}, 2'b01);
        // p2 keeps offering scissors while not ready: must not be recaptured
        p2_move = 2'b11;
        tick();
        chk("hp2_hold_busy", {1'b0, busy}, 2'b01);
        chk("hp2_hold_p1_ready", {1'b0, p1_ready}, 2'b01);
        p1_move = 2'b01;                            // rock vs captured paper
        tick();
        p1_valid = 1'b0; p2_valid = 1'b0;
        chk("hp2_judge_p1_ready", {1'b0, p1_ready}, 2'b00);
        tick();
        chk("hp2_report_result", matchresult, 2'b11);
        tick();
        idle_outputs("hp2_after");

        // p1 paper at cycle 0, p2 scissors B_WAIT cycles later
        p1_valid = 1'b1; p1_move = 2'b10;
        tick();
        p1_valid = 1'b0;
        chk("wait_c1_p1_ready", {1'b0, p1_ready}, 2'b00);
        chk("wait_c1_p2_ready", {1'b0, p2_ready}, 2'b01);
        for (int i = 1; i < B_WAIT; i++) begin
            tick();
            chk("wait_p1_ready", {1'b0, p1_ready}, 2'b00);
            chk("wait_result", matchresult, 2'b00);
        end
        p2_valid = 1'b1; p2_move = 2'b11;
        tick();
        p2_valid = 1'b0;
        chk("wait_judge_p1_ready", {1'b0, p1_ready}, 2'b00);
        chk("wait_judge_result", matchresult, 2'b00);
        tick();
        chk("wait_report_result", matchresult, 2'b11);
        tick();
        idle_outputs("wait_after");

        // Reset pulsed in HAVE_P1
        p1_valid = 1'b1; p1_move = 2'b01;
        tick();
        p1_valid = 1'b0;
        chk("mid_busy_before", {1'b0, busy}, 2'b01);
        #3;
        resetn = 1'b1;
        #1;
        idle_outputs("mid_reset_async");
        tick();
        idle_outputs("mid_reset_held");
        resetn = 1'b0;
        p2_valid = 1'b1; p2_move = 2'b11;
        tick();
        p2_valid = 1'b0;
        chk("post_rst_p2_ready", {1'b0, p2_ready}, 2'b00);
        chk("post_rst_p1_ready", {1'b0, p1_ready}, 2'b01);
        p1_valid = 1'b1; p1_move = 2'b10;           // paper vs scissors
        tick();
        p1_valid = 1'b0;
        tick();
        chk("post_rst_result", matchresult, 2'b11);
        tick();
        idle_outputs("post_rst_after");

`ifdef MATCH_JUDGE_TIMEOUT_EN
        // p2 rock alone: p1 forfeits after 4 cycles in HAVE_P2
        p2_valid = 1'b1; p2_move = 2'b01;
        tick();
        p2_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("tmo_wait_busy", {1'b0, busy}, 2'b01);
            chk("tmo_wait_p1_ready", {1'b0, p1_ready}, 2'b01);
            chk("tmo_wait_result", matchresult, 2'b00);
        end
        tick();
        chk("tmo_judge_p1_ready", {1'b0, p1_ready}, 2'b00);
        tick();
        chk("tmo_forfeit_result", matchresult, 2'b11);
        tick();
        idle_outputs("tmo_after");

        // p1 scissors, p2 rock on the timeout edge: normal decision wins
        p1_valid = 1'b1; p1_move = 2'b11;
        tick();
        p1_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
        end
        chk("tmo_edge_p2_ready", {1'b0, p2_ready}, 2'b01);
        p2_valid = 1'b1; p2_move = 2'b01;
        tick();
        p2_valid = 1'b0;
        tick();
        chk("tmo_edge_result", matchresult, 2'b11);
        tick();
        idle_outputs("tmo_edge_after");
`else
        // Without the timeout a lone move waits indefinitely
        p1_valid = 1'b1; p1_move = 2'b01;
        tick();
        p1_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("nowait_busy", {1'b0, busy}, 2'b01);
            chk("nowait_result", matchresult, 2'b00);
        end
        chk("nowait_p2_ready", {1'b0, p2_ready}, 2'b01);
        p2_valid = 1'b1; p2_move = 2'b11;
        tick();
        p2_valid = 1'b0;
        tick();
        chk("nowait_result_final", matchresult, 2'b10);
        tick();
        idle_outputs("nowait_after");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
